rv32_wb_mux: RTL and testbench

Write-back source selector for the RV32I single-cycle core. It sits between the execute/memory datapath and the register-file write port. It picks one of five 32-bit candidates (ALU, load data, PC+4, U-immediate, PC+imm) under a 3-bit `wb_sel`, and drives the result combinationally in the same cycle. A small clocked side-stage registers the selected value and flags illegal selector codes for trace and debug.

---
 rtl/rv32_pkg.sv | 36 +++
 rtl/rv32_wb_mux.sv | 73 +++++++
 tb/tb_rv32_wb_mux.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32_pkg
// Description : Shared RV32I core definitions: write-back source selector
//               width and encodings. The control decoder and rv32_wb_mux
//               both import this package.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32_pkg;

  // Width of the write-back source selector.
  localparam int WB_SEL_W = 3;

  // Write-back source encodings. Codes 3'b101..3'b111 are undefined.
  typedef enum logic [WB_SEL_W-1:0] {
    WB_ALU   = 3'b000,
    WB_MEM   = 3'b001,
    WB_PC4   = 3'b010,
    WB_LUI   = 3'b011,
    WB_AUIPC = 3'b100
  } wb_sel_e;

  // True only for the five defined selector codes. X/Z bits never match,
  // so an unknown selector is reported as not legal.
  function automatic logic wb_sel_is_legal(input logic [WB_SEL_W-1:0] sel);
    logic legal;
    legal = 1'b0;
    case (sel)
      WB_ALU, WB_MEM, WB_PC4, WB_LUI, WB_AUIPC: legal = 1'b1;
      default:                                  legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage : rv32_pkg
`default_nettype wire

// File: rtl/rv32_wb_mux.sv
`default_nettype none
// ============================================================================
// Module      : rv32_wb_mux
// Description : Write-back source selector for the RV32I single-cycle core.
//               Combinationally picks one of five candidates for the
//               register-file write port, and keeps a registered copy of the
//               retired value plus a sticky illegal-selector flag for
//               trace/debug.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_wb_mux
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WB_SEL_W-1:0] wb_sel,
  input  logic [XLEN-1:0]     alu_result,
  input  logic [XLEN-1:0]     mem_data,
  input  logic [XLEN-1:0]     pc_plus4,
  input  logic [XLEN-1:0]     u_imm,
  input  logic [XLEN-1:0]     pc_plus_imm,
  input  logic                wb_valid,
  input  logic                illegal_clr,
  output logic [XLEN-1:0]     wb_data,
  output logic                sel_illegal,
  output logic [XLEN-1:0]     wb_data_q,
  output logic                wb_valid_q,
  output logic                illegal_seen
);

  // Source selection; undefined or unknown codes fall to the zero default so
  // no X reaches the register file.
  always_comb begin
    wb_data = '0;
    case (wb_sel)
      WB_ALU:   wb_data = alu_result;
      WB_MEM:   wb_data = mem_data;
      WB_PC4:   wb_data = pc_plus4;
      WB_LUI:   wb_data = u_imm;
      WB_AUIPC: wb_data = pc_plus_imm;
      default:  wb_data = '0;
    endcase
  end

  // Illegal-code flag, independent of wb_valid.
  always_comb begin
    sel_illegal = ~wb_sel_is_legal(wb_sel);
  end

  // Trace stage: capture retired data, track valid, and hold a sticky
  // illegal flag where a same-cycle clear beats a new illegal event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_data_q    <= '0;
      wb_valid_q   <= 1'b0;
      illegal_seen <= 1'b0;
    end else begin
      wb_valid_q <= wb_valid;
      if (wb_valid) begin
        wb_data_q <= wb_data;
      end
      if (illegal_clr) begin
        illegal_seen <= 1'b0;
      end else if (wb_valid && sel_illegal) begin
        illegal_seen <= 1'b1;
      end
    end
  end

endmodule : rv32_wb_mux
`default_nettype wire

// File: tb/tb_rv32_wb_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32_wb_mux
// Description : Directed self-checking bench for rv32_wb_mux. Expected values
//               are pushed to a scoreboard when stimulus is applied and
//               popped when the corresponding DUT output is sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_wb_mux;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] ALU   = 32'hAAAA_AAAA;
  localparam logic [XLEN-1:0] MEM   = 32'hBBBB_BBBB;
  localparam logic [XLEN-1:0] PC4   = 32'h0000_0044;
  localparam logic [XLEN-1:0] UIMM  = 32'h1234_5000;
  localparam logic [XLEN-1:0] PCIMM = 32'h0000_1000;

  logic            clk;
  logic            rst_n;
  logic [2:0]      wb_sel;
  logic [XLEN-1:0] alu_result, mem_data, pc_plus4, u_imm, pc_plus_imm;
  logic            wb_valid;
  logic            illegal_clr;
  logic [XLEN-1:0] wb_data;
  logic            sel_illegal;
  logic [XLEN-1:0] wb_data_q;
  logic            wb_valid_q;
  logic            illegal_seen;

  int n_assert = 0;
  int n_fail   = 0;

  // Scoreboard of expected values, consumed in order by chk().
  logic [XLEN-1:0] sb[$];

  rv32_wb_mux #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_sel       (wb_sel),
    .alu_result   (alu_result),
    .mem_data     (mem_data),
    .pc_plus4     (pc_plus4),
    .u_imm        (u_imm),
    .pc_plus_imm  (pc_plus_imm),
    .wb_valid     (wb_valid),
    .illegal_clr  (illegal_clr),
    .wb_data      (wb_data),
    .sel_illegal  (sel_illegal),
    .wb_data_q    (wb_data_q),
    .wb_valid_q   (wb_valid_q),
    .illegal_seen (illegal_seen)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_val(input logic [XLEN-1:0] v);
    sb.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [XLEN-1:0] obs);
    logic [XLEN-1:0] exp_v;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed=%h but scoreboard empty", tag, obs);
    end else begin
      exp_v = sb.pop_front();
      assert (obs === exp_v) else begin
        n_fail++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
      end
    end
  endtask

  // Apply a selector and check the combinational outputs 2 ns later.
  task automatic comb_step(input logic [2:0] sel, input logic [XLEN-1:0] exp_d,
                           input logic exp_ill);
    wb_sel = sel;
    expect_val(exp_d);
    expect_val({{(XLEN-1){1'b0}}, exp_ill});
    #2;
    chk($sformatf("wb_data sel=%b", sel), wb_data);
    chk($sformatf("sel_illegal sel=%b", sel), {{(XLEN-1){1'b0}}, sel_illegal});
  endtask

  // Drive inputs mid-cycle, take one rising edge, settle past it.
  task automatic clk_step(input logic [2:0] sel, input logic vld, input logic clr);
    @(negedge clk);
    wb_sel      = sel;
    wb_valid    = vld;
    illegal_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp_b);
    expect_val({{(XLEN-1){1'b0}}, exp_b});
    chk(tag, {{(XLEN-1){1'b0}}, obs});
  endtask

  initial begin
    rst_n       = 1'b0;
    wb_sel      = 3'b000;
    wb_valid    = 1'b0;
    illegal_clr = 1'b0;
    alu_result  = ALU;
    mem_data    = MEM;
    pc_plus4    = PC4;
    u_imm       = UIMM;
    pc_plus_imm = PCIMM;

    // Reset state.
    #12;
    expect_val('0);
    chk("reset wb_data_q", wb_data_q);
    chk_bit("reset wb_valid_q", wb_valid_q, 1'b0);
    chk_bit("reset illegal_seen", illegal_seen, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Combinational selection, no clock dependence.
    comb_step(3'b000, ALU,   1'b0);
    comb_step(3'b001, MEM,   1'b0);
    comb_step(3'b010, PC4,   1'b0);
    comb_step(3'b011, UIMM,  1'b0);
    comb_step(3'b100, PCIMM, 1'b0);
    comb_step(3'b111, '0,    1'b1);
    comb_step(3'b101, '0,    1'b1);
    comb_step(3'b110, '0,    1'b1);

    // Capture with valid, then hold without valid.
    clk_step(3'b001, 1'b1, 1'b0);
    expect_val(MEM);
    chk("capture wb_data_q", wb_data_q);
    chk_bit("capture wb_valid_q", wb_valid_q, 1'b1);
    clk_step(3'b000, 1'b0, 1'b0);
    expect_val(MEM);
    chk("hold wb_data_q", wb_data_q);
    chk_bit("hold wb_valid_q", wb_valid_q, 1'b0);
    chk_bit("no illegal yet", illegal_seen, 1'b0);

    // Illegal code without valid must not set the sticky flag.
    clk_step(3'b111, 1'b0, 1'b0);
    chk_bit("illegal without valid", illegal_seen, 1'b0);

    // Sticky flag set, held, cleared, and clear-wins.
    clk_step(3'b110, 1'b1, 1'b0);
    chk_bit("illegal_seen set", illegal_seen, 1'b1);
    expect_val('0);
    chk("illegal capture zero", wb_data_q);
    clk_step(3'b010, 1'b1, 1'b0);
    chk_bit("illegal_seen sticky", illegal_seen, 1'b1);
    expect_val(PC4);
    chk("capture pc4", wb_data_q);
    clk_step(3'b000, 1'b0, 1'b1);
    chk_bit("illegal_seen cleared", illegal_seen, 1'b0);
    clk_step(3'b101, 1'b1, 1'b1);
    chk_bit("clear wins", illegal_seen, 1'b0);
    clk_step(3'b101, 1'b1, 1'b0);
    chk_bit("illegal_seen set again", illegal_seen, 1'b1);

    // Load data, then asynchronous reset between edges.
    clk_step(3'b011, 1'b1, 1'b0);
    expect_val(UIMM);
    chk("preload wb_data_q", wb_data_q);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    expect_val('0);
    chk("async reset wb_data_q", wb_data_q);
    chk_bit("async reset wb_valid_q", wb_valid_q, 1'b0);
    chk_bit("async reset illegal_seen", illegal_seen, 1'b0);
    expect_val(PCIMM);
    wb_sel = 3'b100;
    #1;
    chk("comb during reset", wb_data);

    // Held in reset across an edge with valid asserted.
    wb_valid = 1'b1;
    @(posedge clk);
    #1;
    expect_val('0);
    chk("reset holds wb_data_q", wb_data_q);

    // Release between edges; first edge captures normally.
    @(negedge clk);
    rst_n    = 1'b1;
    wb_sel   = 3'b010;
    wb_valid = 1'b1;
    @(posedge clk);
    #1;
    expect_val(PC4);
    chk("post-reset capture", wb_data_q);
    chk_bit("post-reset wb_valid_q", wb_valid_q, 1'b1);

    if (sb.size() != 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard: %0d leftover entries, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_rv32_wb_mux
`default_nettype wire
